uart_frame_ctrl: RTL and testbench
==================================

# uart_frame_ctrl

Packet-level controller that sits directly behind the UART receiver. It drains received bytes over the receiver's `dout`/`rdy`/`rdy_clr` handshake and hunts for a sync byte. It parses each frame (sync, length, payload, checksum) into an internal buffer, and releases the payload to downstream logic over a valid/ready stream only after the checksum verifies. Malformed, corrupt or stalled frames are dropped and reported.

## Interface
Parameters:
- `SYNC`, 8'hA5, frame start marker.
- `MAX_LEN`, 16, maximum payload bytes (buffer depth, 1..255).
- `TIMEOUT`, 50000, maximum `clk50` cycles allowed between accepted bytes inside a frame.

Ports:
- `clk50`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_dout`  in  8  receiver data byte.
- `rx_rdy`  in  1  receiver byte-available flag.
- `rx_rdy_clr`  out  1  one-cycle pulse that acknowledges a byte to the receiver.
- `pkt_data`  out  8  payload byte; valid while `pkt_valid`.
- `pkt_valid`  out  1  payload byte available.
- `pkt_ready`  in  1  downstream accepts the current byte.
- `pkt_last`  out  1  qualifies the final payload byte of a frame.
- `frame_ok`  out  1  one-cycle pulse: frame verified.
- `frame_err`  out  1  one-cycle pulse: frame dropped.
- `err_code`  out  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.

## Operation
- Reset values: `rx_rdy_clr`=0, `pkt_valid`=0, `pkt_last`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, state=HUNT, all counters=0.
- Byte accept: in HUNT/LEN/PAYLOAD/CSUM, a byte is accepted on a cycle with `rx_rdy`=1 and `rx_rdy_clr`=0. The next cycle has `rx_rdy_clr`=1 for exactly one cycle.
  - `rx_rdy` is ignored while `rx_rdy_clr`=1, so one byte is never consumed twice.
- HUNT: an accepted byte != `SYNC` is discarded silently. A byte == `SYNC` moves to LEN and clears the running sum.
- LEN: accepted byte L.
  - L==0 or L>`MAX_LEN`: error 1, go to HUNT.
  - Otherwise: store L, sum=L, write index=0, go to PAYLOAD.
- PAYLOAD: each accepted byte is written to buf[index]. Index increments and sum += byte (8-bit, mod 256). After L bytes, go to CSUM.
- CSUM: accepted byte C.
  - C==sum: go to DRAIN.
  - Otherwise: error 2, go to HUNT.
  - A `SYNC` value is treated as data in LEN/PAYLOAD/CSUM, not as a resync.
- DRAIN: `pkt_valid`=1, `pkt_data`=buf[rd_idx], `pkt_last`=(rd_idx==L-1).
  - Transfer on `pkt_valid`&&`pkt_ready`; rd_idx increments.
  - The cycle after the last transfer, `pkt_valid`=0 and state=HUNT.
  - No bytes are accepted in DRAIN; `rx_rdy_clr` stays 0. A receiver overrun during long backpressure loses data; that is acceptable.
- Timeout: in LEN/PAYLOAD/CSUM, a cycle counter resets on each accepted byte and on entry from HUNT. When it reaches `TIMEOUT`: error 3, go to HUNT. Counter width is clog2(`TIMEOUT`+1).
- Error action: `frame_err` pulses one cycle, `err_code` is loaded, state=HUNT, buffered data is discarded. `err_code` holds until the next error or reset; `frame_ok` does not clear it.
- Simultaneous events: a timeout expiring in the same cycle a byte is accepted is not an error; the byte wins.
- Reset mid-operation: everything returns to reset values at the next edge, including during DRAIN (`pkt_valid` drops with no `pkt_last`). A byte still pending in the receiver is consumed afterwards in HUNT.

## Timing
- Byte accepted in cycle N → `rx_rdy_clr`=1 in N+1 → `rx_rdy` low from N+2.
- Checksum byte accepted in cycle N → `frame_ok`=1 and `pkt_valid`=1 in N+1.
- Error detected on a byte accepted in N → `frame_err` pulse and `err_code` update in N+1.
- Timeout: `frame_err` asserts exactly `TIMEOUT`+1 cycles after the last accepted byte.
- DRAIN throughput is one byte per cycle while `pkt_ready`=1. `pkt_data`/`pkt_last` are held stable while `pkt_valid`&&!`pkt_ready`.
- Minimum HUNT re-entry: the byte following the last drained transfer may be accepted in the first HUNT cycle.

## Test plan
- Good frame A5 03 11 22 33 69 → `frame_ok` pulse once; `pkt_data` 11,22,33; `pkt_last` only on 33; `err_code`=0; one `rx_rdy_clr` pulse per byte.
- Leading junk 00 FF A5 01 7E 7F → junk dropped silently; single byte 7E out with `pkt_last`=1.
- A5 03 11 22 33 68 → `frame_err`, `err_code`=2, no `pkt_valid`. A following good frame passes.
- A5 00 and A5 11 (`MAX_LEN`=16) → each gives `err_code`=1 immediately after the length byte, and the parser resyncs on the next A5.
- Good frame with `pkt_ready` toggling 0/1 each cycle → data held stable while stalled, all 3 bytes delivered in order.
- A5 03 11, then no input (`TIMEOUT`=100) → `frame_err`, `err_code`=3, 101 cycles after byte 11. Separately, `rst` during PAYLOAD → outputs reset next edge and a fresh frame passes.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Purpose  : Hunts sync, parses sync/len/payload/csum frames from a UART
//            receiver and releases verified payloads on a valid/ready stream.
// Revision : 1.0
// ============================================================================
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50000
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic [7:0] rx_dout,
  input  logic       rx_rdy,
  output logic       rx_rdy_clr,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [1:0]      ERR_LEN   = 2'd1;
  localparam logic [1:0]      ERR_CSUM  = 2'd2;
  localparam logic [1:0]      ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rdy_clr_q, rdy_clr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic [7:0]      buf_d [MAX_LEN];

  logic accept;
  logic in_frame;
  logic is_last;

  // A byte is only taken when the previous acknowledge has been seen by the receiver.
  assign accept   = rx_rdy && !rdy_clr_q && (state_q != ST_DRAIN);
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign is_last  = (8'(rd_idx_q) == (len_q - 8'd1));

  always_comb begin
    state_d   = state_q;
    rdy_clr_d = accept;
    len_d     = len_q;
    sum_d     = sum_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    tmo_d     = '0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    buf_d     = buf_q;

    if (in_frame && !accept) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (accept && (rx_dout == SYNC)) begin
          sum_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if ((rx_dout == 8'd0) || (rx_dout > MAX_LEN_B)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_HUNT;
          end else begin
            len_d    = rx_dout;
            sum_d    = rx_dout;
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          buf_d[wr_idx_q] = rx_dout;
          sum_d           = sum_q + rx_dout;
          wr_idx_d        = wr_idx_q + 1'b1;
          if (8'(wr_idx_q) == (len_q - 8'd1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_dout == sum_q) begin
            ok_d     = 1'b1;
            rd_idx_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        if (pkt_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (is_last) begin
            rd_idx_d = '0;
            state_d  = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // An accepted byte in the expiry cycle keeps the frame alive.
    if (in_frame && !accept && (tmo_q == TMO_LAST)) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      tmo_d   = '0;
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      rdy_clr_q <= 1'b0;
      len_q     <= '0;
      sum_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      tmo_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdy_clr_q <= rdy_clr_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      tmo_q     <= tmo_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  always_ff @(posedge clk50) begin
    buf_q <= buf_d;
  end

  assign rx_rdy_clr = rdy_clr_q;
  assign pkt_valid  = (state_q == ST_DRAIN);
  assign pkt_data   = buf_q[rd_idx_q];
  assign pkt_last   = pkt_valid && is_last;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Purpose  : Receiver emulation plus downstream backpressure, checked against a
//            frame-level model of which payloads and errors each stream yields.
// Revision : 1.0
// ============================================================================
module tb_uart_frame_ctrl;

  localparam logic [7:0] SYNC       = 8'hA5;
  localparam int         MAX_LEN    = 16;
  localparam int         TIMEOUT    = 100;
  localparam int         WAIT_LIMIT = 2000;

  logic       clk50 = 1'b0;
  logic       rst;
  logic [7:0] rx_dout;
  logic       rx_rdy;
  logic       rx_rdy_clr;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int ready_mode = 0;

  logic [7:0] exp_data [$];
  bit         exp_last [$];
  int         exp_err  [$];
  int         exp_ok   = 0;
  int         exp_clr  = 0;

  logic [7:0] got_data [$];
  bit         got_last [$];
  int         got_err  [$];
  int         got_ok   = 0;
  int         got_clr  = 0;
  int         clr_cyc    = 0;
  int         ok_cyc     = 0;
  int         err_cyc    = 0;
  int         vstart_cyc = 0;
  int         data_idx   = 0;
  int         err_idx    = 0;

  bit         stalled    = 1'b0;
  bit         prev_valid = 1'b0;
  logic [7:0] held_data  = 8'd0;
  bit         held_last  = 1'b0;

  uart_frame_ctrl #(
    .SYNC    (SYNC),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk50      (clk50),
    .rst        (rst),
    .rx_dout    (rx_dout),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_last   (pkt_last),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Downstream sink: 0 always ready, 1 random, 2 toggling, 3 never ready.
  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk50);
      #1;
      case (ready_mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = 1'($urandom_range(0, 1));
        2:       pkt_ready = ~pkt_ready;
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  // Observer: records transfers, pulses and hold-stability while stalled.
  initial begin
    forever begin
      @(negedge clk50);
      if (!rst) begin
        if (stalled) begin
          chk("hold_valid", int'(pkt_valid), 1);
          chk("hold_data", int'(pkt_data), int'(held_data));
          chk("hold_last", int'(pkt_last), int'(held_last));
        end
        if (rx_rdy_clr) begin got_clr++; clr_cyc = cyc; end
        if (frame_ok)   begin got_ok++;  ok_cyc  = cyc; end
        if (frame_err)  begin got_err.push_back(int'(err_code)); err_cyc = cyc; end
        if (pkt_valid && !prev_valid) vstart_cyc = cyc;
        if (pkt_valid && pkt_ready) begin
          got_data.push_back(pkt_data);
          got_last.push_back(pkt_last);
        end
        stalled    = pkt_valid && !pkt_ready;
        held_data  = pkt_data;
        held_last  = pkt_last;
        prev_valid = pkt_valid;
      end else begin
        stalled    = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  // Frame-level outcome of a byte stream, assuming the line goes idle afterwards.
  task automatic model(input logic [7:0] s [$]);
    int i;
    int len;
    int sum;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
      end else if (i + 1 >= s.size()) begin
        exp_err.push_back(3);
        i = s.size();
      end else begin
        len = int'(s[i+1]);
        if (len == 0 || len > MAX_LEN) begin
          exp_err.push_back(1);
          i += 2;
        end else if (i + 2 + len >= s.size()) begin
          exp_err.push_back(3);
          i = s.size();
        end else begin
          sum = len;
          for (int j = 0; j < len; j++) sum += int'(s[i+2+j]);
          if (int'(s[i+2+len]) == (sum % 256)) begin
            exp_ok++;
            for (int j = 0; j < len; j++) begin
              exp_data.push_back(s[i+2+j]);
              exp_last.push_back(j == len - 1);
            end
          end else begin
            exp_err.push_back(2);
          end
          i += len + 3;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    repeat ($urandom_range(1, 3)) @(posedge clk50);
    #1;
    rx_dout = b;
    rx_rdy  = 1'b1;
    exp_clr++;
    do begin
      @(negedge clk50);
      t++;
    end while (!rx_rdy_clr && t < WAIT_LIMIT);
    if (!rx_rdy_clr) chk("rdy_clr_wait", 0, 1);
    @(posedge clk50);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic compare();
    chk("n_bytes", got_data.size(), exp_data.size());
    chk("n_errs", got_err.size(), exp_err.size());
    chk("n_ok", got_ok, exp_ok);
    chk("n_clr", got_clr, exp_clr);
    while (data_idx < got_data.size() && data_idx < exp_data.size()) begin
      chk("data", int'(got_data[data_idx]), int'(exp_data[data_idx]));
      chk("last", int'(got_last[data_idx]), int'(exp_last[data_idx]));
      data_idx++;
    end
    while (err_idx < got_err.size() && err_idx < exp_err.size()) begin
      chk("err_code", got_err[err_idx], exp_err[err_idx]);
      err_idx++;
    end
  endtask

  task automatic run_stream(input logic [7:0] q [$]);
    int t;
    model(q);
    foreach (q[i]) send_byte(q[i]);
    repeat (TIMEOUT + 10) @(negedge clk50);
    t = 0;
    while (pkt_valid && t < WAIT_LIMIT) begin
      @(negedge clk50);
      t++;
    end
    if (pkt_valid) chk("drain_wait", 1, 0);
    compare();
  endtask

  task automatic gen_stream(output logic [7:0] q [$]);
    int kind;
    int len;
    int sum;
    logic [7:0] b;
    q = {};
    repeat ($urandom_range(2, 5)) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom_range(0, 255));
          q.push_back((b == SYNC) ? 8'h5A : b);
        end
      end else if (kind == 5) begin
        q.push_back(SYNC);
        q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        sum = len;
        q.push_back(SYNC);
        q.push_back(8'(len));
        repeat (len) begin
          b = 8'($urandom_range(0, 255));
          sum += int'(b);
          q.push_back(b);
        end
        b = 8'(sum % 256);
        if (kind == 4) b = b ^ 8'($urandom_range(1, 255));
        q.push_back(b);
      end
    end
  endtask

  initial begin
    logic [7:0] q [$];

    rst     = 1'b1;
    rx_rdy  = 1'b0;
    rx_dout = 8'd0;
    repeat (3) @(posedge clk50);
    #1;
    rst = 1'b0;
    @(negedge clk50);
    chk("rst_rdy_clr", int'(rx_rdy_clr), 0);
    chk("rst_valid", int'(pkt_valid), 0);
    chk("rst_last", int'(pkt_last), 0);
    chk("rst_ok", int'(frame_ok), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_code", int'(err_code), 0);

    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    run_stream(q);
    chk("ok_latency", ok_cyc, clr_cyc);
    chk("valid_latency", vstart_cyc, ok_cyc);
    chk("code_after_good", int'(err_code), 0);

    q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_stream(q);

    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'hA5, 8'h02, 8'h40, 8'h41, 8'h83};
    run_stream(q);
    chk("code_holds_over_ok", int'(err_code), 2);

    q = '{8'hA5, 8'h00};
    run_stream(q);
    chk("len0_latency", err_cyc, clr_cyc);
    q = '{8'hA5, 8'h11};
    run_stream(q);
    chk("len17_latency", err_cyc, clr_cyc);
    q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_stream(q);

    ready_mode = 2;
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    run_stream(q);
    ready_mode = 0;

    q = '{8'hA5, 8'd16};
    for (int j = 0; j < 16; j++) q.push_back(8'(j * 17 + 1));
    q.push_back(8'd0);
    begin
      int s;
      s = 16;
      for (int j = 0; j < 16; j++) s += int'(q[2+j]);
      q[18] = 8'(s % 256);
    end
    run_stream(q);

    q = '{8'hA5, 8'h03, 8'h11};
    run_stream(q);
    chk("timeout_latency", err_cyc - (clr_cyc - 1), TIMEOUT + 1);
    chk("timeout_code", int'(err_code), 3);

    // Reset while mid-payload.
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    @(posedge clk50); #1; rst = 1'b1;
    @(posedge clk50); #1; rst = 1'b0;
    @(negedge clk50);
    chk("rst_mid_code", int'(err_code), 0);
    chk("rst_mid_err", int'(frame_err), 0);
    chk("rst_mid_valid", int'(pkt_valid), 0);
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    run_stream(q);

    // Reset while a verified frame is stalled in drain.
    ready_mode = 3;
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    foreach (q[i]) send_byte(q[i]);
    exp_ok++;
    repeat (4) @(negedge clk50);
    chk("drain_stalled", int'(pkt_valid), 1);
    @(posedge clk50); #1; rst = 1'b1;
    @(posedge clk50); #1; rst = 1'b0;
    @(negedge clk50);
    chk("rst_drain_valid", int'(pkt_valid), 0);
    chk("rst_drain_last", int'(pkt_last), 0);
    ready_mode = 0;
    compare();

    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      gen_stream(q);
      run_stream(q);
    end
    if (exp_err.size() > 0) chk("code_final", int'(err_code), exp_err[exp_err.size()-1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected finish before %0d cycles", 90000);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
